// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared types for the front-end redirect controller: request sources, FSM states,
// the PC-write request shape and the per-stage flush vector.
package fetch_redirect_ctrl_pkg;

  localparam int unsigned REDIR_VADDR_W = 32;

  // Encoded so that a numerically larger source has higher priority.
  typedef enum logic [1:0] {
    F2 = 2'd0,
    EX = 2'd1,
    CM = 2'd2
  } redir_src_e;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    HALT = 2'd2
  } redir_state_e;

  typedef struct packed {
    logic                     valid;
    logic [REDIR_VADDR_W-1:0] pc;
    logic                     is_predict;
  } redir_req_t;

  typedef struct packed {
    logic f1;
    logic f2;
    logic be;
  } redir_flush_t;

  function automatic redir_flush_t flush_for(input redir_src_e src);
    redir_flush_t f;
    f = '0;
    case (src)
      CM:      f = '{f1: 1'b1, f2: 1'b1, be: 1'b1};
      EX:      f = '{f1: 1'b1, f2: 1'b1, be: 1'b0};
      default: f = '{f1: 1'b1, f2: 1'b0, be: 1'b0};
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// Redirect request/response bundle between the pipeline stages and the redirect controller.
interface fetch_redirect_ctrl_if
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned VADDR_W = REDIR_VADDR_W
);

  logic               f2_req_valid;
  logic [VADDR_W-1:0] f2_req_pc;
  logic               f2_req_is_predict;
  logic               ex_req_valid;
  logic [VADDR_W-1:0] ex_req_pc;
  logic               cm_req_valid;
  logic [VADDR_W-1:0] cm_req_pc;
  logic               cm_idle;
  logic [VADDR_W-1:0] cm_idle_pc;
  logic               wake;
  logic               f1_ready;

  logic               pc_req_valid;
  logic [VADDR_W-1:0] pc_req_pc;
  logic               pc_req_is_predict;
  logic               flush_f1;
  logic               flush_f2;
  logic               flush_be;
  logic               fetch_halt;
  logic               busy;

  modport master (
    output f2_req_valid, f2_req_pc, f2_req_is_predict,
    output ex_req_valid, ex_req_pc,
    output cm_req_valid, cm_req_pc, cm_idle, cm_idle_pc,
    output wake, f1_ready,
    input  pc_req_valid, pc_req_pc, pc_req_is_predict,
    input  flush_f1, flush_f2, flush_be, fetch_halt, busy
  );

  modport slave (
    input  f2_req_valid, f2_req_pc, f2_req_is_predict,
    input  ex_req_valid, ex_req_pc,
    input  cm_req_valid, cm_req_pc, cm_idle, cm_idle_pc,
    input  wake, f1_ready,
    output pc_req_valid, pc_req_pc, pc_req_is_predict,
    output flush_f1, flush_f2, flush_be, fetch_halt, busy
  );

endinterface

// File: rtl/fetch_redirect_ctrl_prio_sel.sv
// Combinational priority select among idle/commit/execute/fetch2 redirects.
// Produces the single winner, its source and the flush lines it implies.
module redir_prio_sel
  import fetch_redirect_ctrl_pkg::*;
(
  input  logic                     f2_req_valid,
  input  logic [REDIR_VADDR_W-1:0] f2_req_pc,
  input  logic                     f2_req_is_predict,
  input  logic                     ex_req_valid,
  input  logic [REDIR_VADDR_W-1:0] ex_req_pc,
  input  logic                     cm_req_valid,
  input  logic [REDIR_VADDR_W-1:0] cm_req_pc,
  input  logic                     cm_idle,
  input  logic [REDIR_VADDR_W-1:0] cm_idle_pc,
  output redir_req_t               win,
  output redir_src_e               win_src,
  output logic                     win_idle,
  output redir_flush_t             flush
);

  always_comb begin
    win      = '0;
    win_src  = F2;
    win_idle = 1'b0;
    if (cm_idle) begin
      win.valid = 1'b1;
      win.pc    = cm_idle_pc;
      win_src   = CM;
      win_idle  = 1'b1;
    end else if (cm_req_valid) begin
      win.valid = 1'b1;
      win.pc    = cm_req_pc;
      win_src   = CM;
    end else if (ex_req_valid) begin
      win.valid = 1'b1;
      win.pc    = ex_req_pc;
      win_src   = EX;
    end else if (f2_req_valid) begin
      win.valid      = 1'b1;
      win.pc         = f2_req_pc;
      win.is_predict = f2_req_is_predict;
      win_src        = F2;
    end
  end

  always_comb begin
    flush = '0;
    if (win.valid) flush = flush_for(win_src);
  end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Front-end PC redirect arbiter: priority select, per-stage flushes, a one-entry
// pending register held until fetch1 accepts, and an idle/wake halt state.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int unsigned        VADDR_W = REDIR_VADDR_W,
  parameter logic [VADDR_W-1:0] RST_PC  = 32'h1c00_0000
)(
  input  logic                  clk,
  input  logic                  rst,
  fetch_redirect_ctrl_if.slave  bus
);

  redir_state_e       state_q, state_d;
  logic [VADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic               pend_pred_q, pend_pred_d;
  redir_src_e         pend_src_q, pend_src_d;

  redir_req_t         win;
  redir_src_e         win_src;
  logic               win_idle;
  redir_flush_t       sel_flush;

  logic               pc_valid;
  logic [VADDR_W-1:0] pc_out;
  logic               pc_pred;
  redir_flush_t       flush;
  logic               halt;
  logic               overwrite;

  redir_prio_sel u_prio_sel (
    .f2_req_valid      (bus.f2_req_valid),
    .f2_req_pc         (bus.f2_req_pc),
    .f2_req_is_predict (bus.f2_req_is_predict),
    .ex_req_valid      (bus.ex_req_valid),
    .ex_req_pc         (bus.ex_req_pc),
    .cm_req_valid      (bus.cm_req_valid),
    .cm_req_pc         (bus.cm_req_pc),
    .cm_idle           (bus.cm_idle),
    .cm_idle_pc        (bus.cm_idle_pc),
    .win               (win),
    .win_src           (win_src),
    .win_idle          (win_idle),
    .flush             (sel_flush)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= PEND;
      pend_pc_q   <= RST_PC;
      pend_pred_q <= 1'b0;
      pend_src_q  <= CM;
    end else begin
      state_q     <= state_d;
      pend_pc_q   <= pend_pc_d;
      pend_pred_q <= pend_pred_d;
      pend_src_q  <= pend_src_d;
    end
  end

  assign overwrite = win.valid && (win_src >= pend_src_q);

  always_comb begin
    state_d     = state_q;
    pend_pc_d   = pend_pc_q;
    pend_pred_d = pend_pred_q;
    pend_src_d  = pend_src_q;
    pc_valid    = 1'b0;
    pc_out      = pend_pc_q;
    pc_pred     = pend_pred_q;
    flush       = '0;
    halt        = 1'b0;

    case (state_q)
      RUN: begin
        if (win.valid) begin
          flush       = sel_flush;
          pend_pc_d   = win.pc;
          pend_pred_d = win.is_predict;
          pend_src_d  = win_src;
          if (win_idle) begin
            state_d = HALT;
          end else begin
            pc_valid = 1'b1;
            pc_out   = win.pc;
            pc_pred  = win.is_predict;
            if (!bus.f1_ready) state_d = PEND;
          end
        end
      end

      PEND: begin
        if (overwrite) begin
          flush       = sel_flush;
          pend_pc_d   = win.pc;
          pend_pred_d = win.is_predict;
          pend_src_d  = win_src;
          // An idle overtaking a pending redirect parks immediately; the stale PC is not issued.
          if (win_idle) begin
            state_d = HALT;
          end else begin
            pc_valid = 1'b1;
            pc_out   = win.pc;
            pc_pred  = win.is_predict;
            if (bus.f1_ready) state_d = RUN;
          end
        end else begin
          pc_valid = 1'b1;
          if (bus.f1_ready) state_d = RUN;
        end
      end

      HALT: begin
        halt = 1'b1;
        if (bus.cm_req_valid) begin
          flush       = flush_for(CM);
          pend_pc_d   = bus.cm_req_pc;
          pend_pred_d = 1'b0;
          pend_src_d  = CM;
          state_d     = PEND;
        end else if (bus.wake) begin
          state_d = PEND;
        end
      end

      default: state_d = PEND;
    endcase
  end

  assign bus.pc_req_valid      = pc_valid;
  assign bus.pc_req_pc         = pc_out;
  assign bus.pc_req_is_predict = pc_pred;
  assign bus.flush_f1          = flush.f1;
  assign bus.flush_f2          = flush.f2;
  assign bus.flush_be          = flush.be;
  assign bus.fetch_halt        = halt;
  assign bus.busy              = (state_q != RUN);

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: expected PC writes are queued when stimulus
// is driven and retired when fetch1 accepts; flush/halt/busy checked per cycle.
module tb_fetch_redirect_ctrl;
  import fetch_redirect_ctrl_pkg::*;

  localparam logic [31:0] RST_PC = 32'h1c00_0000;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  redir_req_t exp_q[$];

  fetch_redirect_ctrl_if #(.VADDR_W(32)) bus ();

  fetch_redirect_ctrl #(.VADDR_W(32), .RST_PC(RST_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    bus.f2_req_valid      = 1'b0;
    bus.f2_req_pc         = '0;
    bus.f2_req_is_predict = 1'b0;
    bus.ex_req_valid      = 1'b0;
    bus.ex_req_pc         = '0;
    bus.cm_req_valid      = 1'b0;
    bus.cm_req_pc         = '0;
    bus.cm_idle           = 1'b0;
    bus.cm_idle_pc        = '0;
    bus.wake              = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc, input logic pred);
    exp_q.push_back('{valid: 1'b1, pc: pc, is_predict: pred});
  endtask

  task automatic chk_flush(input string tag, input logic f1, input logic f2, input logic be);
    check({tag, "_flush"}, {bus.flush_f1, bus.flush_f2, bus.flush_be}, {f1, f2, be});
  endtask

  // Retire one expected PC each time fetch1 accepts a write.
  always @(negedge clk) begin
    if (!rst && bus.pc_req_valid && bus.f1_ready) begin
      redir_req_t e;
      check("sb_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("pc_req_pc", bus.pc_req_pc, e.pc);
        check("pc_req_is_predict", bus.pc_req_is_predict, e.is_predict);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    clr();
    bus.f1_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push(RST_PC, 1'b0);
    @(negedge clk);
    chk_flush("reset", 0, 0, 0);
    check("reset_busy", bus.busy, 1);
    check("reset_halt", bus.fetch_halt, 0);
    check("reset_pcv", bus.pc_req_valid, 1);
    check("reset_pc", bus.pc_req_pc, RST_PC);
    tick(); @(negedge clk);
    check("run_busy", bus.busy, 0);
    check("run_idle_pcv", bus.pc_req_valid, 0);

    // EX beats F2 in the same cycle
    tick(); clr();
    bus.f2_req_valid = 1'b1; bus.f2_req_pc = 32'h1c00_0100; bus.f2_req_is_predict = 1'b1;
    bus.ex_req_valid = 1'b1; bus.ex_req_pc = 32'h1c00_0200;
    push(32'h1c00_0200, 1'b0);
    @(negedge clk);
    chk_flush("ex_vs_f2", 1, 1, 0);

    // F2 alone carries is_predict
    tick(); clr();
    bus.f2_req_valid = 1'b1; bus.f2_req_pc = 32'h1c00_0104; bus.f2_req_is_predict = 1'b1;
    push(32'h1c00_0104, 1'b1);
    @(negedge clk);
    chk_flush("f2_only", 1, 0, 0);

    // EX held while fetch1 stalls; F2 during pending is dropped
    tick(); clr(); bus.f1_ready = 1'b0;
    bus.ex_req_valid = 1'b1; bus.ex_req_pc = 32'h1c00_0300;
    push(32'h1c00_0300, 1'b0);
    @(negedge clk);
    chk_flush("ex_stall0", 1, 1, 0);
    tick(); clr(); @(negedge clk);
    chk_flush("ex_stall1", 0, 0, 0);
    check("ex_stall1_busy", bus.busy, 1);
    tick(); bus.f2_req_valid = 1'b1; bus.f2_req_pc = 32'h1c00_0400; @(negedge clk);
    chk_flush("f2_ignored", 0, 0, 0);
    tick(); clr(); bus.f1_ready = 1'b1; @(negedge clk);
    tick(); @(negedge clk);
    check("ex_drain_busy", bus.busy, 0);

    // CM overwrites a pending EX
    tick(); clr(); bus.f1_ready = 1'b0;
    bus.ex_req_valid = 1'b1; bus.ex_req_pc = 32'h1c00_0300;
    @(negedge clk);
    tick(); clr(); bus.cm_req_valid = 1'b1; bus.cm_req_pc = 32'h1c00_8000;
    push(32'h1c00_8000, 1'b0);
    @(negedge clk);
    chk_flush("cm_over_ex", 1, 1, 1);
    tick(); clr(); @(negedge clk);
    chk_flush("cm_pend", 0, 0, 0);
    tick(); bus.f1_ready = 1'b1; @(negedge clk);
    tick(); @(negedge clk);
    check("cm_drain_busy", bus.busy, 0);

    // Equal-priority overwrite together with f1_ready: new PC issued at once
    tick(); clr(); bus.f1_ready = 1'b0;
    bus.ex_req_valid = 1'b1; bus.ex_req_pc = 32'h1c00_0300;
    @(negedge clk);
    tick(); bus.ex_req_pc = 32'h1c00_0600; bus.f1_ready = 1'b1;
    push(32'h1c00_0600, 1'b0);
    @(negedge clk);
    chk_flush("ex_over_ex", 1, 1, 0);
    tick(); clr(); @(negedge clk);
    check("ex_over_busy", bus.busy, 0);
    check("ex_over_pcv", bus.pc_req_valid, 0);

    // Idle, ignored EX while halted, wake
    tick(); clr(); bus.cm_idle = 1'b1; bus.cm_idle_pc = 32'h1c00_0500; @(negedge clk);
    chk_flush("idle", 1, 1, 1);
    check("idle_pcv", bus.pc_req_valid, 0);
    tick(); clr(); @(negedge clk);
    check("halt_halt", bus.fetch_halt, 1);
    check("halt_busy", bus.busy, 1);
    check("halt_pcv", bus.pc_req_valid, 0);
    tick(); bus.ex_req_valid = 1'b1; bus.ex_req_pc = 32'h1c00_0700; @(negedge clk);
    chk_flush("halt_ex", 0, 0, 0);
    check("halt_ex_pcv", bus.pc_req_valid, 0);
    tick(); clr(); bus.wake = 1'b1; push(32'h1c00_0500, 1'b0); @(negedge clk);
    check("wake_halt", bus.fetch_halt, 1);
    check("wake_pcv", bus.pc_req_valid, 0);
    tick(); clr(); @(negedge clk);
    check("woken_halt", bus.fetch_halt, 0);
    tick(); @(negedge clk);
    check("woken_busy", bus.busy, 0);

    // CM and wake together while halted: CM wins
    tick(); clr(); bus.cm_idle = 1'b1; bus.cm_idle_pc = 32'h1c00_0900; @(negedge clk);
    tick(); clr(); @(negedge clk);
    tick(); bus.cm_req_valid = 1'b1; bus.cm_req_pc = 32'h1c00_a000; bus.wake = 1'b1;
    push(32'h1c00_a000, 1'b0);
    @(negedge clk);
    chk_flush("halt_cm", 1, 1, 1);
    tick(); clr(); @(negedge clk);
    check("halt_cm_halt", bus.fetch_halt, 0);
    tick(); @(negedge clk);

    // Reset while pending discards the pending PC
    tick(); clr(); bus.f1_ready = 1'b0;
    bus.ex_req_valid = 1'b1; bus.ex_req_pc = 32'h1c00_0300;
    @(negedge clk);
    tick(); clr(); rst = 1'b1;
    tick(); tick();
    rst = 1'b0; bus.f1_ready = 1'b1;
    push(RST_PC, 1'b0);
    @(negedge clk);
    check("rerst_pc", bus.pc_req_pc, RST_PC);
    tick(); tick(); @(negedge clk);
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
Central PC-redirect arbiter and scheduler for the front end. Collects redirect requests from fetch2 (branch-prediction correction), execute (branch mispredict) and commit (exception/ertn/refetch/idle). Picks one per cycle by priority, drives the per-stage flush lines, and delivers the winning PC to fetch1. If fetch1 cannot accept the PC, the redirect is held until it can. Also parks the front end while the core is idle and wakes it on interrupt.

Parameters:
VADDR_W, 32, virtual PC width
RST_PC, 32'h1c00_0000, PC issued in the first cycle after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
f2_req_valid  in  1  fetch2 redirect (prediction fix/advance/return repredict)
f2_req_pc  in  VADDR_W  fetch2 target
f2_req_is_predict  in  1  target is itself a prediction
ex_req_valid  in  1  execute branch-mispredict redirect
ex_req_pc  in  VADDR_W  execute target
cm_req_valid  in  1  commit redirect (exception, ertn, refetch)
cm_req_pc  in  VADDR_W  commit target
cm_idle  in  1  commit retired idle; halt front end
cm_idle_pc  in  VADDR_W  PC at which fetch resumes on wake
wake  in  1  interrupt pending; leave HALT
f1_ready  in  1  fetch1 accepts a PC this cycle
pc_req_valid  out  1  PC write to fetch1
pc_req_pc  out  VADDR_W  PC to fetch1
pc_req_is_predict  out  1  carried to fetch1 next.is_predict
flush_f1  out  1  flush fetch1
flush_f2  out  1  flush fetch2
flush_be  out  1  flush decode through execute
fetch_halt  out  1  fetch1 must not issue icache requests
busy  out  1  a redirect is pending or the block is halted

Behaviour:
- States: RUN, PEND, HALT. Pending register holds pc, is_predict and src (F2/EX/CM).
- Reset: state is PEND with pending = {RST_PC, is_predict 0, src CM}. All flush outputs are 0. fetch_halt is 0. pc_req_valid is asserted from the first cycle after rst drops.
- Priority: cm_idle > cm_req > ex_req > f2_req. Only the winner is considered. Losers in the same cycle are dropped.
- Flushes are combinational and asserted in the arrival cycle only. They are never re-asserted while a redirect is pending.
  - CM or idle: flush_f1, flush_f2 and flush_be.
  - EX: flush_f1 and flush_f2.
  - F2: flush_f1 only.
- pc_req_valid = (state==PEND) OR (state==RUN and a winner exists). Outputs come from the pending register in PEND, otherwise from the winner.
  - EX and CM force is_predict to 0.
- RUN:
  - Winner present and f1_ready: issue the PC, stay in RUN.
  - Winner present and ~f1_ready: latch the winner, go to PEND.
  - cm_idle: latch cm_idle_pc, go to HALT. No pc_req is issued.
- PEND:
  - f1_ready: pc_req fires and state returns to RUN.
  - A new request of equal or higher priority than src overwrites the pending entry and asserts its flushes.
  - A new request of strictly lower priority is ignored. Fetch2 requests during a pending EX/CM redirect belong to the wrong path.
  - If f1_ready and an overwrite occur in the same cycle, the overwrite wins: the new PC is issued in that cycle and state goes to RUN.
- HALT:
  - fetch_halt = 1 and pc_req_valid = 0.
  - f2_req and ex_req are ignored.
  - cm_req overrides the halt with flushes; go to PEND with cm_req_pc.
  - wake: go to PEND with the stored idle PC (issued once f1_ready).
  - cm_req and wake together: cm_req wins.
- busy = (state != RUN).
- rst mid-operation discards the pending entry and HALT, then follows reset behaviour.
- The PC is carried unmodified; there is no arithmetic. An unaligned PC is passed through and the ADEF check is done downstream.

Decomposition:
- Shared package: redir_src_e {F2, EX, CM}, redir_state_e {RUN, PEND, HALT}, and redir_req_t {valid, pc, is_predict}. This is the same shape as the existing wr_pc_req_t; reuse it directly.
- Sub-module redir_prio_sel: purely combinational priority select producing winner, src and flush vector. The FSM and pending register stay in the top module.

Test Plan:
- Release rst with f1_ready=1 → pc_req_valid=1 and pc_req_pc=0x1c000000 in the first cycle; next cycle busy=0.
- Same cycle f2_req(0x1c000100, is_predict=1) and ex_req(0x1c000200), f1_ready=1 → pc_req_pc=0x1c000200, is_predict=0, flush_f1=flush_f2=1, flush_be=0.
- ex_req(0x1c000300) with f1_ready=0 for 3 cycles; f2_req(0x1c000400) in cycle 2 → flushes only in cycle 0, f2 ignored; 0x1c000300 issued when f1_ready rises.
- PEND holding EX 0x1c000300; cm_req(0x1c008000) arrives → all three flushes for one cycle; 0x1c008000 issued when f1_ready.
- cm_idle(pc=0x1c000500) → fetch_halt=1 and no pc_req; ex_req while halted ignored; wake with f1_ready=1 → pc_req 0x1c000500 next cycle, fetch_halt=0.
- rst asserted while in PEND with 0x1c000300 → after release, RST_PC is issued and 0x1c000300 never appears.
